// File: rtl/fifo_drain.sv
// rtl/fifo_drain.sv - drains xfer_len words from a FIFO RAM port into a 2-entry valid/ready output buffer
module fifo_drain #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  xfer_len,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  rd_a_strb,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    state_t                  state, state_next;
    logic [CNT_WIDTH-1:0]    issue_cnt, deliv_cnt;
    logic                    strb_q;
    logic [DATA_WIDTH-1:0]   buf0, buf1;
    logic [1:0]              occ;
    logic                    strb, pop, capture;

    // fifo_empty lags the FIFO count by a cycle, so a read is never issued right after another
    assign strb    = !reset && (state == RUN) && enable && !fifo_empty && !strb_q &&
                     (issue_cnt != '0) && ((occ + {1'b0, strb_q}) < 2'd2);
    assign capture = strb_q;
    assign pop     = out_valid && out_ready;

    assign rd_a_strb = strb;
    assign out_valid = (occ != 2'd0);
    assign out_data  = buf0;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (xfer_len == '0) ? DONE : RUN;
            RUN:     if (issue_cnt == '0) state_next = DRAIN;
            DRAIN:   if ((deliv_cnt == '0) || ((deliv_cnt == CNT_ONE) && pop)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            issue_cnt <= '0;
            deliv_cnt <= '0;
            strb_q    <= 1'b0;
            buf0      <= '0;
            buf1      <= '0;
            occ       <= 2'd0;
        end else begin
            state  <= state_next;
            strb_q <= strb;

            if ((state == IDLE) && start) begin
                issue_cnt <= xfer_len;
                deliv_cnt <= xfer_len;
            end else begin
                if (strb) issue_cnt <= issue_cnt - CNT_ONE;
                if (pop)  deliv_cnt <= deliv_cnt - CNT_ONE;
            end

            // buf0 is always the oldest entry; a pop shifts buf1 down
            case ({capture, pop})
                2'b10: begin
                    if (occ == 2'd0) buf0 <= fifo_rd_data;
                    else             buf1 <= fifo_rd_data;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    buf0 <= buf1;
                    buf1 <= '0;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    buf0 <= (occ == 2'd1) ? fifo_rd_data : buf1;
                    buf1 <= (occ == 2'd1) ? '0 : fifo_rd_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_drain.sv
// tb/tb_fifo_drain.sv - self-checking bench for fifo_drain with a behavioural FIFO and scoreboard
module tb_fifo_drain;

    localparam int DW = 32;
    localparam int CW = 10;
    localparam int SZ = 4096;

    logic          clk = 1'b0;
    logic          reset = 1'b1, enable = 1'b0, start = 1'b0, out_ready = 1'b0;
    logic [CW-1:0] xfer_len = '0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          rd_a_strb, out_valid, busy, done;
    logic [DW-1:0] out_data;

    fifo_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .start(start), .xfer_len(xfer_len),
        .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data), .rd_a_strb(rd_a_strb),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int compared = 0, mismatched = 0;

    // FIFO controller model: registered empty flag lagging the count, data one cycle after strobe
    logic [DW-1:0] fifo_mem [SZ];
    int  wr_ptr = 0, rd_ptr = 0, underflow = 0;
    logic flush = 1'b0;
    always @(posedge clk) begin
        fifo_empty <= (wr_ptr == rd_ptr);
        if (flush) begin
            rd_ptr = wr_ptr;
            fifo_rd_data <= $urandom;
        end else if (rd_a_strb === 1'b1 && wr_ptr != rd_ptr) begin
            fifo_rd_data <= fifo_mem[rd_ptr % SZ];
            rd_ptr = rd_ptr + 1;
        end else begin
            if (rd_a_strb === 1'b1) underflow++;
            fifo_rd_data <= $urandom;
        end
    end

    // Monitor: records accepted words and protocol violations away from the active edge
    int cyc = 0, n_strb = 0, n_done = 0, b2b_err = 0, hold_err = 0, occ_err = 0, empty_err = 0;
    int outstanding = 0, last_acc_cyc = 0, done_cyc = 0;
    logic prev_strb = 1'b0, hold_pend = 1'b0;
    logic [DW-1:0] hold_val = '0;
    logic [DW-1:0] rx[$];
    int strb_cyc[$];
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            prev_strb = 1'b0; hold_pend = 1'b0; outstanding = 0;
        end else begin
            if (rd_a_strb === 1'b1) begin
                n_strb++; strb_cyc.push_back(cyc);
                if (prev_strb) b2b_err++;
                if (fifo_empty) empty_err++;
            end
            prev_strb = (rd_a_strb === 1'b1);
            if (hold_pend && (out_valid !== 1'b1 || out_data !== hold_val)) hold_err++;
            if (out_valid && out_ready) begin
                rx.push_back(out_data); last_acc_cyc = cyc;
            end
            hold_pend = out_valid && !out_ready;
            hold_val = out_data;
            outstanding += ((rd_a_strb === 1'b1) ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
            if (outstanding > 2) occ_err++;
            if (done === 1'b1) begin n_done++; done_cyc = cyc; end
        end
    end

    int b_strb, b_done, b_rx, b_hold, b_b2b, b_occ, b_empty, b_under, b_sc;
    logic [DW-1:0] w[$];

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic snap();
        b_strb = n_strb; b_done = n_done; b_rx = rx.size(); b_hold = hold_err; b_b2b = b2b_err;
        b_occ = occ_err; b_empty = empty_err; b_under = underflow; b_sc = strb_cyc.size();
    endtask

    task automatic do_flush();
        flush = 1'b1; step(); flush = 1'b0; step(); step();
    endtask

    task automatic load(input int n, input bit seq);
        logic [DW-1:0] v;
        for (int i = 0; i < n; i++) begin
            v = seq ? DW'(i + 1) : $urandom;
            w.push_back(v);
            fifo_mem[wr_ptr % SZ] = v;
            wr_ptr++;
        end
    endtask

    task automatic do_start(input int len);
        start = 1'b1; xfer_len = CW'(len); step(); start = 1'b0; xfer_len = CW'($urandom);
    endtask

    task automatic run_until_done(input int max_cyc, input bit rnd, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (rnd) begin
                out_ready = ($urandom_range(0, 1) == 1);
                enable = ($urandom_range(0, 3) != 0);
            end
            step();
            if (n_done > b_done) begin ok = 1'b1; break; end
        end
        out_ready = 1'b1; enable = 1'b1;
        repeat (4) step();
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; xfer_len = 10'd5; enable = 1'b1; out_ready = 1'b1;
        step(); step();
        compared++; if (rd_a_strb !== 1'b0) begin mismatched++; $display("FAIL reset_strb: got %b want 0", rd_a_strb); end
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        compared++; if (out_data !== '0) begin mismatched++; $display("FAIL reset_data: got %h want 0", out_data); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
        compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b want 0", done); end
        start = 1'b0; reset = 1'b0; step();
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic();
        bit ok; int bad = 0; logic [DW-1:0] got;
        do_flush(); w.delete(); load(8, 1'b1); enable = 1'b1; out_ready = 1'b1; step(); step();
        snap(); do_start(4); run_until_done(200, 1'b0, ok);
        compared++; if (ok !== 1'b1) begin mismatched++; $display("FAIL basic_timeout: got %b want 1", ok); end
        compared++; if (n_strb - b_strb != 4) begin mismatched++; $display("FAIL basic_strobes: got %0d want 4", n_strb - b_strb); end
        for (int i = b_sc + 1; i < strb_cyc.size(); i++) if (strb_cyc[i] - strb_cyc[i-1] != 2) bad++;
        compared++; if (bad != 0) begin mismatched++; $display("FAIL basic_alt_cycles: got %0d bad gaps want 0", bad); end
        compared++; if (rx.size() - b_rx != 4) begin mismatched++; $display("FAIL basic_count: got %0d want 4", rx.size() - b_rx); end
        for (int i = 0; i < 4; i++) begin
            got = (b_rx + i < rx.size()) ? rx[b_rx + i] : 'x;
            compared++; if (got !== DW'(i + 1)) begin mismatched++; $display("FAIL basic_word%0d: got %h want %h", i, got, i + 1); end
        end
        compared++; if (done_cyc != last_acc_cyc + 1) begin mismatched++; $display("FAIL basic_done_lat: got %0d want %0d", done_cyc, last_acc_cyc + 1); end
        compared++; if (wr_ptr - rd_ptr != 4) begin mismatched++; $display("FAIL basic_left: got %0d want 4", wr_ptr - rd_ptr); end
        compared++; if (n_done - b_done != 1) begin mismatched++; $display("FAIL basic_done_cnt: got %0d want 1", n_done - b_done); end
    endtask

    task automatic test_zero_len();
        snap(); do_start(0);
        compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL zero_busy: got %b want 1", busy); end
        compared++; if (done !== 1'b1) begin mismatched++; $display("FAIL zero_done: got %b want 1", done); end
        step();
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL zero_busy_after: got %b want 0", busy); end
        compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL zero_done_after: got %b want 0", done); end
        step();
        compared++; if (n_strb - b_strb != 0) begin mismatched++; $display("FAIL zero_strobes: got %0d want 0", n_strb - b_strb); end
    endtask

    task automatic test_backpressure();
        bit ok; logic [DW-1:0] got;
        do_flush(); w.delete(); load(6, 1'b0); out_ready = 1'b0; step(); step();
        snap(); do_start(6); repeat (20) step();
        compared++; if (n_strb - b_strb != 2) begin mismatched++; $display("FAIL bp_strobes: got %0d want 2", n_strb - b_strb); end
        compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL bp_valid: got %b want 1", out_valid); end
        compared++; if (out_data !== w[0]) begin mismatched++; $display("FAIL bp_data: got %h want %h", out_data, w[0]); end
        compared++; if (hold_err != b_hold) begin mismatched++; $display("FAIL bp_stable: got %0d want %0d", hold_err, b_hold); end
        out_ready = 1'b1; run_until_done(200, 1'b0, ok);
        compared++; if (ok !== 1'b1) begin mismatched++; $display("FAIL bp_timeout: got %b want 1", ok); end
        compared++; if (rx.size() - b_rx != 6) begin mismatched++; $display("FAIL bp_count: got %0d want 6", rx.size() - b_rx); end
        for (int i = 0; i < 6; i++) begin
            got = (b_rx + i < rx.size()) ? rx[b_rx + i] : 'x;
            compared++; if (got !== w[i]) begin mismatched++; $display("FAIL bp_word%0d: got %h want %h", i, got, w[i]); end
        end
        compared++; if (n_done - b_done != 1) begin mismatched++; $display("FAIL bp_done_cnt: got %0d want 1", n_done - b_done); end
    endtask

    task automatic test_empty_stall();
        bit ok; logic [DW-1:0] got;
        do_flush(); w.delete(); load(2, 1'b0); out_ready = 1'b1; step(); step();
        snap(); do_start(5); repeat (10) step();
        compared++; if (n_strb - b_strb != 2) begin mismatched++; $display("FAIL stall_strobes: got %0d want 2", n_strb - b_strb); end
        compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL stall_busy: got %b want 1", busy); end
        load(3, 1'b0); run_until_done(200, 1'b0, ok);
        compared++; if (ok !== 1'b1) begin mismatched++; $display("FAIL stall_timeout: got %b want 1", ok); end
        compared++; if (rx.size() - b_rx != 5) begin mismatched++; $display("FAIL stall_count: got %0d want 5", rx.size() - b_rx); end
        for (int i = 0; i < 5; i++) begin
            got = (b_rx + i < rx.size()) ? rx[b_rx + i] : 'x;
            compared++; if (got !== w[i]) begin mismatched++; $display("FAIL stall_word%0d: got %h want %h", i, got, w[i]); end
        end
        compared++; if (underflow != b_under) begin mismatched++; $display("FAIL stall_underflow: got %0d want %0d", underflow, b_under); end
        compared++; if (empty_err != b_empty) begin mismatched++; $display("FAIL stall_strb_on_empty: got %0d want %0d", empty_err, b_empty); end
    endtask

    task automatic test_reset_mid();
        bit ok; int used; logic [DW-1:0] expv, got;
        do_flush(); w.delete(); load(6, 1'b0); out_ready = 1'b1; step(); step();
        snap(); do_start(4);
        for (int i = 0; i < 20 && rd_a_strb !== 1'b1; i++) step();
        step();
        reset = 1'b1; step();
        compared++; if (rd_a_strb !== 1'b0) begin mismatched++; $display("FAIL rmid_strb: got %b want 0", rd_a_strb); end
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
        compared++; if (out_data !== '0) begin mismatched++; $display("FAIL rmid_data: got %h want 0", out_data); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rmid_busy: got %b want 0", busy); end
        compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL rmid_done: got %b want 0", done); end
        reset = 1'b0; step(); step();
        compared++; if (n_done != b_done) begin mismatched++; $display("FAIL rmid_no_done: got %0d want %0d", n_done - b_done, 0); end
        used = n_strb - b_strb; expv = w[used];
        snap(); do_start(1); run_until_done(100, 1'b0, ok);
        got = (b_rx < rx.size()) ? rx[b_rx] : 'x;
        compared++; if (ok !== 1'b1) begin mismatched++; $display("FAIL rmid_timeout: got %b want 1", ok); end
        compared++; if (got !== expv) begin mismatched++; $display("FAIL rmid_next_word: got %h want %h", got, expv); end
        compared++; if (rx.size() - b_rx != 1) begin mismatched++; $display("FAIL rmid_count: got %0d want 1", rx.size() - b_rx); end
    endtask

    task automatic test_restart_ignored();
        bit ok; logic [DW-1:0] got;
        do_flush(); w.delete(); load(10, 1'b0); out_ready = 1'b1; step(); step();
        snap(); do_start(3); step();
        start = 1'b1; xfer_len = 10'd7; step(); start = 1'b0;
        run_until_done(200, 1'b0, ok);
        compared++; if (ok !== 1'b1) begin mismatched++; $display("FAIL restart_timeout: got %b want 1", ok); end
        compared++; if (n_strb - b_strb != 3) begin mismatched++; $display("FAIL restart_strobes: got %0d want 3", n_strb - b_strb); end
        compared++; if (rx.size() - b_rx != 3) begin mismatched++; $display("FAIL restart_count: got %0d want 3", rx.size() - b_rx); end
        for (int i = 0; i < 3; i++) begin
            got = (b_rx + i < rx.size()) ? rx[b_rx + i] : 'x;
            compared++; if (got !== w[i]) begin mismatched++; $display("FAIL restart_word%0d: got %h want %h", i, got, w[i]); end
        end
        compared++; if (n_done - b_done != 1) begin mismatched++; $display("FAIL restart_done_cnt: got %0d want 1", n_done - b_done); end
        compared++; if (wr_ptr - rd_ptr != 7) begin mismatched++; $display("FAIL restart_left: got %0d want 7", wr_ptr - rd_ptr); end
    endtask

    task automatic test_random();
        bit ok; int len; logic [DW-1:0] got;
        for (int it = 0; it < 6; it++) begin
            len = $urandom_range(1, 12);
            do_flush(); w.delete(); load(len + $urandom_range(0, 3), 1'b0); step(); step();
            snap(); do_start(len); run_until_done(600, 1'b1, ok);
            compared++; if (ok !== 1'b1) begin mismatched++; $display("FAIL rnd%0d_timeout: got %b want 1", it, ok); end
            compared++; if (n_strb - b_strb != len) begin mismatched++; $display("FAIL rnd%0d_strobes: got %0d want %0d", it, n_strb - b_strb, len); end
            compared++; if (rx.size() - b_rx != len) begin mismatched++; $display("FAIL rnd%0d_count: got %0d want %0d", it, rx.size() - b_rx, len); end
            for (int i = 0; i < len; i++) begin
                got = (b_rx + i < rx.size()) ? rx[b_rx + i] : 'x;
                compared++; if (got !== w[i]) begin mismatched++; $display("FAIL rnd%0d_word%0d: got %h want %h", it, i, got, w[i]); end
            end
            compared++; if (n_done - b_done != 1) begin mismatched++; $display("FAIL rnd%0d_done_cnt: got %0d want 1", it, n_done - b_done); end
            compared++; if (hold_err != b_hold) begin mismatched++; $display("FAIL rnd%0d_stable: got %0d want %0d", it, hold_err, b_hold); end
            compared++; if (b2b_err != b_b2b) begin mismatched++; $display("FAIL rnd%0d_back_to_back: got %0d want %0d", it, b2b_err, b_b2b); end
            compared++; if (occ_err != b_occ) begin mismatched++; $display("FAIL rnd%0d_occupancy: got %0d want %0d", it, occ_err, b_occ); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_backpressure();
        test_empty_stall();
        test_reset_mid();
        test_restart_ignored();
        test_random();
        compared++; if (b2b_err != 0) begin mismatched++; $display("FAIL back_to_back_total: got %0d want 0", b2b_err); end
        compared++; if (underflow != 0) begin mismatched++; $display("FAIL underflow_total: got %0d want 0", underflow); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fifo_drain.md
FIFO_DRAIN -- requirements
Module: fifo_drain

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of one FIFO RAM word.
REQ-002 SHALL have parameter CNT_WIDTH, default 10, width of transfer length and FIFO address space.
REQ-003 SHALL have a single clock and a synchronous, active-high reset, as listed below.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 enable  input  1  when 0, no new FIFO reads issued; output handshake continues.
REQ-007 start  input  1  single-cycle pulse requesting a transfer of xfer_len words.
REQ-008 xfer_len  input  CNT_WIDTH  number of words to drain; sampled on accepted start.
REQ-009 fifo_empty  input  1  registered empty flag from the FIFO controller.
REQ-010 fifo_rd_data  input  DATA_WIDTH  RAM port-A read data; valid the cycle after rd_a_strb.
REQ-011 rd_a_strb  output  1  read strobe to the FIFO controller, one word per high cycle.
REQ-012 out_data  output  DATA_WIDTH  downstream word.
REQ-013 out_valid  output  1  out_data holds a valid word.
REQ-014 out_ready  input  1  downstream accepts the word when out_valid && out_ready.
REQ-015 busy  output  1  high from accepted start until done pulse, inclusive.
REQ-016 done  output  1  single-cycle pulse: all xfer_len words accepted downstream.

Function
REQ-017 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-018 IDLE: start with xfer_len != 0 SHALL latch xfer_len into issue and delivery counters and go to RUN next cycle.
REQ-019 IDLE: start with xfer_len == 0 SHALL go to DONE (no reads).
REQ-020 start while not IDLE SHALL be ignored.
REQ-021 RUN: rd_a_strb SHALL assert only when enable=1, fifo_empty=0, rd_a_strb was 0 the previous cycle, issue counter != 0, and (buffer occupancy + in-flight reads) < 2.
REQ-022 The no-back-to-back rule SHALL hold because fifo_empty lags the FIFO count by one cycle; peak throughput is one word per two cycles.
REQ-023 Each strobe SHALL decrement the issue counter; at issue counter 0 the FSM SHALL go to DRAIN.
REQ-024 The word on fifo_rd_data one cycle after a strobe SHALL be written into a 2-entry output buffer, preserving order.
REQ-025 out_valid SHALL be high whenever the buffer is non-empty; out_data SHALL be the oldest entry, stable while out_valid && !out_ready.
REQ-026 Each out_valid && out_ready cycle SHALL pop one entry and decrement the delivery counter; simultaneous capture and pop SHALL keep occupancy unchanged.
REQ-027 DRAIN: when the delivery counter reaches 0, FSM SHALL go to DONE.
REQ-028 DONE SHALL last exactly one cycle with done=1, then IDLE.
REQ-029 busy SHALL be 1 in RUN, DRAIN, DONE; 0 in IDLE.
REQ-030 Counters SHALL be CNT_WIDTH bits; max transfer 2^CNT_WIDTH-1 words; no wrap possible.
REQ-031 enable=0 mid-transfer SHALL pause issue only; in-flight word SHALL still be captured.
REQ-032 fifo_empty=1 in RUN SHALL stall issue indefinitely without error.

Reset
REQ-033 reset SHALL force IDLE, rd_a_strb=0, out_valid=0, out_data=0, busy=0, done=0, counters and buffer cleared.
REQ-034 reset mid-transfer SHALL discard any in-flight read and buffered words; no done pulse.
REQ-035 reset SHALL take priority over all other inputs in the same cycle.

Verification
REQ-036 FIFO holds 8 words 0x1..0x8, out_ready=1, start with xfer_len=4 -> strobes on alternate cycles, out_data 0x1,0x2,0x3,0x4 in order, done one cycle after 4th acceptance, 4 words left in FIFO.
REQ-037 start with xfer_len=0 -> no rd_a_strb, busy=1 and done=1 on the following cycle only, then IDLE.
REQ-038 xfer_len=6, out_ready=0 for 20 cycles -> exactly 2 strobes, out_data=word0 held stable; releasing out_ready completes all 6 words, done pulses once.
REQ-039 FIFO empty after 2 of 5 words, refilled 10 cycles later -> strobes stop while fifo_empty=1, resume after, 5 words delivered, no duplicates or gaps.
REQ-040 reset asserted in RUN with one read in flight -> next cycle all outputs at reset values; new start with xfer_len=1 delivers the next FIFO word correctly.
REQ-041 start pulsed again during RUN with different xfer_len -> ignored; original length delivered, single done.
